pipelined_adder: RTL

Parametrised, pipelined ripple-carry adder/subtractor that splits a WIDTH-bit operation into STAGES carry-registered segments of SEG bits each. It is the successor to the fixed 9-bit combinational ripple adder. It serves the wider multiplier and datapath work, where a single-cycle ripple chain no longer meets timing. It accepts one operation per cycle through a valid/ready handshake, stalls cleanly under back-pressure, and reports carry-out and signed overflow alongside the sum.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/adder_segment.sv | 30 +++
 rtl/full_adder.sv | 13 +
 rtl/pipelined_adder.sv | 99 +++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the pipelined adder/subtractor.
// stage_t is sized for the widest supported datapath; each instance uses the low WIDTH bits.
package adder_pkg;

  localparam int MAX_WIDTH = 64;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int stages(int width, int seg);
    return (seg < 1) ? 1 : width / seg;
  endfunction

  // ovf is only meaningful in the last stage, where the MSB segment is resolved.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 ovf;
    logic [MAX_WIDTH-1:0] sum;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
  } stage_t;

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple adder with carry in/out and a tap on the carry into the MSB.
module adder_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           msb_ci
);

  logic [SEG:0] c;

  assign c[0] = ci;

  for (genvar k = 0; k < SEG; k++) begin : g_bit
    full_adder u_fa (
      .a  (a[k]),
      .b  (b[k]),
      .ci (c[k]),
      .s  (s[k]),
      .co (c[k+1])
    );
  end

  assign co     = c[SEG];
  assign msb_ci = c[SEG-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple segments.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage, carry registered between stages.
// Valid/ready: a transfer happens on a rising edge where valid && ready; the whole pipe advances together.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             OVF,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = stages(WIDTH, SEG);

  if (SEG < 1 || (WIDTH % SEG) != 0 || WIDTH > MAX_WIDTH) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a non-zero multiple of SEG and at most MAX_WIDTH");
  end

  stage_t [STAGES-1:0] stage_d;
  stage_t [STAGES-1:0] stage_q;
  stage_t              head;
  logic [WIDTH-1:0]    b_mode;
  logic                adv;
  logic                unused_pipe;

  // No bubble collapsing: the pipe either moves as a whole or freezes as a whole.
  assign out_valid = stage_q[STAGES-1].valid;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Subtraction is A + ~B + 1, with the +1 entering as the stage-0 carry-in.
  assign b_mode = (Sub == MODE_SUB) ? ~B : B;

  always_comb begin
    head                 = '0;
    head.valid           = in_valid;
    head.carry           = (Sub == MODE_SUB);
    head.a[WIDTH-1:0]    = A;
    head.b[WIDTH-1:0]    = b_mode;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    stage_t         src;
    stage_t         d;
    logic [SEG-1:0] seg_sum;
    logic           seg_co;
    logic           seg_msb_ci;

    if (i == 0) begin : g_head
      assign src = head;
    end else begin : g_chain
      assign src = stage_q[i-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .a      (src.a[i*SEG +: SEG]),
      .b      (src.b[i*SEG +: SEG]),
      .ci     (src.carry),
      .s      (seg_sum),
      .co     (seg_co),
      .msb_ci (seg_msb_ci)
    );

    always_comb begin
      d                   = src;
      d.carry             = seg_co;
      d.ovf               = seg_co ^ seg_msb_ci;
      d.sum[i*SEG +: SEG] = seg_sum;
    end

    assign stage_d[i] = d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stage_q <= '0;
    end else if (adv) begin
      stage_q <= stage_d;
    end
  end

  assign Sum = stage_q[STAGES-1].sum[WIDTH-1:0];
  assign CO  = stage_q[STAGES-1].carry;
  assign OVF = stage_q[STAGES-1].ovf;

  // Operand bits already consumed and sum bits above WIDTH are never read.
  assign unused_pipe = ^stage_q;

endmodule
